// File: rtl/uart_rx.sv
// 8N1 serial receiver with a valid/ready byte holding register. Optional UART_RX_GLITCH_FILTER_EN adds a 3-sample majority filter.
// Latency: byte and error pulses register on the clock after the mid-stop-bit sample.
// Backpressure: none on the line. A byte that completes while valid is held and not being consumed is dropped, and overrun pulses.
module uart_rx #(
   parameter int CLKS_PER_BIT = 345
) (
   input  logic       clk_core,
   input  logic       resetn,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   input  logic       ready,
   output logic       frame_err,
   output logic       overrun
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] LAST    = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       idx;
   logic [7:0]       shift;
   logic             sync1, sync2;
   logic             s;

   always_ff @(posedge clk_core or negedge resetn) begin
      if (!resetn) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= rx;
         sync2 <= sync1;
      end
   end

`ifdef UART_RX_GLITCH_FILTER_EN
   // The majority window is sync2 plus its two previous values, so one extra clock of latency.
   logic [1:0] flt;

   always_ff @(posedge clk_core or negedge resetn) begin
      if (!resetn) flt <= 2'b11;
      else         flt <= {flt[0], sync2};
   end

   assign s = (sync2 & flt[0]) | (sync2 & flt[1]) | (flt[0] & flt[1]);
`else
   assign s = sync2;
`endif

   always_ff @(posedge clk_core or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         cnt       <= '0;
         idx       <= 3'd0;
         shift     <= 8'h00;
         data      <= 8'h00;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         // A delivery in STOP below overrides this clear.
         if (valid && ready) valid <= 1'b0;

         case (state)
            IDLE: begin
               if (!s) begin
                  state <= START;
                  cnt   <= '0;
               end
            end
            START: begin
               if (cnt == HALF_M1) begin
                  if (s) begin
                     state <= IDLE;
                  end else begin
                     state <= DATA;
                     cnt   <= '0;
                     idx   <= 3'd0;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DATA: begin
               if (cnt == LAST) begin
                  shift <= {s, shift[7:1]};
                  cnt   <= '0;
                  idx   <= idx + 3'd1;
                  if (idx == 3'd7) state <= STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            STOP: begin
               if (cnt == LAST) begin
                  if (s) begin
                     if (!valid || ready) begin
                        data  <= shift;
                        valid <= 1'b1;
                     end else begin
                        overrun <= 1'b1;
                     end
                     state <= IDLE;
                  end else begin
                     frame_err <= 1'b1;
                     state     <= WAIT_HIGH;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            WAIT_HIGH: begin
               if (s) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: table of single frames plus hand-written corner sequences.
module tb_uart_rx;

   localparam int CPB  = 16;
   localparam int HALF = CPB / 2;
`ifdef UART_RX_GLITCH_FILTER_EN
   localparam int SLAT = 3;
`else
   localparam int SLAT = 2;
`endif
   // Posedges from the rx falling edge to valid being visible.
   localparam int EXP_LAT = SLAT + HALF + 9 * CPB + 1;

   logic       clk_core = 1'b0;
   logic       resetn   = 1'b0;
   logic       rx       = 1'b1;
   logic       ready    = 1'b0;
   logic [7:0] data;
   logic       valid;
   logic       frame_err;
   logic       overrun;

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk_core  (clk_core),
      .resetn    (resetn),
      .rx        (rx),
      .data      (data),
      .valid     (valid),
      .ready     (ready),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   always #5 clk_core = ~clk_core;

   int cyc = 0;
   always @(posedge clk_core) cyc++;

   int         fe_cnt, ov_cnt, vld_cyc, rise_cyc, fall_cyc;
   logic       vld_seen;
   logic [7:0] cap;

   always @(negedge clk_core) begin
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (valid) begin
         vld_cyc++;
         if (!vld_seen) begin
            vld_seen = 1'b1;
            rise_cyc = cyc;
            cap      = data;
         end
      end
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk_core);
      #1;
   endtask

   task automatic clear_counts();
      fe_cnt   = 0;
      ov_cnt   = 0;
      vld_cyc  = 0;
      vld_seen = 1'b0;
      rise_cyc = 0;
      cap      = 8'h00;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, input logic after);
      rx       = 1'b0;
      fall_cyc = cyc;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         tick(CPB);
      end
      rx = stop;
      tick(CPB);
      rx = after;
   endtask

   function automatic int latency();
      return vld_seen ? (rise_cyc - fall_cyc) : -1;
   endfunction

   typedef struct {
      logic [7:0] dat;
      logic       stop;
      int         exp_vld;
      int         exp_fe;
      logic [7:0] exp_data;
   } vec_t;

   vec_t vecs[6];

   initial begin
      vecs[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
      vecs[1] = '{8'h00, 1'b1, 1, 0, 8'h00};
      vecs[2] = '{8'h55, 1'b0, 0, 1, 8'h00};
      vecs[3] = '{8'h0F, 1'b1, 1, 0, 8'h0F};
      vecs[4] = '{8'h80, 1'b1, 1, 0, 8'h80};
      vecs[5] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
      clear_counts();
      fall_cyc = 0;

      tick(3);
      check("rst_data", data, 8'h00);
      check("rst_valid", valid, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_overrun", overrun, 0);
      resetn = 1'b1;
      tick(5);

      ready = 1'b1;
      for (int v = 0; v < 6; v++) begin
         clear_counts();
         send_frame(vecs[v].dat, vecs[v].stop, 1'b1);
         tick(20);
         check($sformatf("vec%0d_valid_cycles", v), vld_cyc, vecs[v].exp_vld);
         check($sformatf("vec%0d_data", v), cap, vecs[v].exp_data);
         check($sformatf("vec%0d_frame_err", v), fe_cnt, vecs[v].exp_fe);
         check($sformatf("vec%0d_overrun", v), ov_cnt, 0);
         check($sformatf("vec%0d_latency", v), latency(), (vecs[v].exp_vld != 0) ? EXP_LAT : -1);
      end

      // Back-to-back frames with no consumer: second byte is dropped.
      clear_counts();
      ready = 1'b0;
      send_frame(8'h3C, 1'b1, 1'b1);
      send_frame(8'hC3, 1'b1, 1'b1);
      tick(20);
      check("b2b_overrun", ov_cnt, 1);
      check("b2b_data", data, 8'h3C);
      check("b2b_valid_held", valid, 1);
      check("b2b_frame_err", fe_cnt, 0);
      ready = 1'b1;
      tick(1);
      check("b2b_valid_cleared", valid, 0);
      tick(2);

      // Break: stop bit low then line held low for 40 bit times.
      clear_counts();
      send_frame(8'h55, 1'b0, 1'b0);
      tick(40 * CPB);
      rx = 1'b1;
      tick(20);
      check("break_frame_err_once", fe_cnt, 1);
      check("break_no_valid", vld_cyc, 0);
      clear_counts();
      send_frame(8'h0F, 1'b1, 1'b1);
      tick(20);
      check("after_break_data", cap, 8'h0F);
      check("after_break_valid", vld_cyc, 1);
      check("after_break_frame_err", fe_cnt, 0);

      // 4-clock low pulse, then a frame started right after the false start resolves.
      clear_counts();
      rx = 1'b0;
      tick(4);
      rx = 1'b1;
      tick(8);
      send_frame(8'h3A, 1'b1, 1'b1);
      tick(20);
      check("false_start_frame_err", fe_cnt, 0);
      check("false_start_valid_cycles", vld_cyc, 1);
      check("false_start_next_data", cap, 8'h3A);
      check("false_start_next_latency", latency(), EXP_LAT);

      // 1-clock glitch on idle line.
      clear_counts();
      rx = 1'b0;
      tick(1);
      rx = 1'b1;
      tick(30);
      check("idle_glitch_valid", vld_cyc, 0);
      check("idle_glitch_frame_err", fe_cnt, 0);

      // Reset during data bit 4 of 8'hFF while a previous byte is held.
      clear_counts();
      ready = 1'b0;
      send_frame(8'h99, 1'b1, 1'b1);
      tick(20);
      check("pre_reset_valid", valid, 1);
      rx = 1'b0;
      tick(CPB);
      rx = 1'b1;
      tick(4 * CPB + 8);
      resetn = 1'b0;
      #1;
      check("midreset_data", data, 8'h00);
      check("midreset_valid", valid, 0);
      tick(5);
      check("inreset_valid", valid, 0);
      check("inreset_frame_err", frame_err, 0);
      resetn = 1'b1;
      ready  = 1'b1;
      tick(3 * CPB);
      clear_counts();
      send_frame(8'h01, 1'b1, 1'b1);
      tick(20);
      check("post_reset_valid_cycles", vld_cyc, 1);
      check("post_reset_data", cap, 8'h01);
      check("post_reset_frame_err", fe_cnt, 0);
      check("post_reset_overrun", ov_cnt, 0);

`ifdef UART_RX_GLITCH_FILTER_EN
      // One-clock low glitch in the middle of every data bit and the stop bit.
      clear_counts();
      rx       = 1'b0;
      fall_cyc = cyc;
      tick(CPB);
      for (int i = 0; i < 9; i++) begin
         rx = 1'b1;
         tick(CPB / 2);
         rx = 1'b0;
         tick(1);
         rx = 1'b1;
         tick(CPB / 2 - 1);
      end
      tick(20);
      check("filter_data", cap, 8'hFF);
      check("filter_valid_cycles", vld_cyc, 1);
      check("filter_frame_err", fe_cnt, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
